// File: rtl/buyruk_on_getir.sv
// Instruction prefetch buffer: keeps a small FIFO of fetched words filled
// from the L1 instruction cache and serves the head entry to decode.
// Redirects and flushes clear the FIFO. A fetch that is still waiting in the
// cache at that point is let to finish and its word is dropped.
module buyruk_on_getir #(
    parameter int          DERINLIK     = 4,
    parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        l1b_bekle_i,
    input  logic [31:0]                 l1b_deger_i,
    output logic                        l1b_chip_select_n_o,
    output logic [31:0]                 l1b_adres_o,
    input  logic                        yrt_atlanan_ps_gecerli_i,
    input  logic [30:0]                 yrt_atlanan_ps_i,
    input  logic                        ddb_bosalt_i,
    input  logic                        ddb_durdur_i,
    output logic                        cyo_gecerli_o,
    output logic [31:0]                 cyo_buyruk_o,
    output logic [30:0]                 cyo_ps_o,
    output logic [30:0]                 cyo_ps_artmis_o,
    output logic [$clog2(DERINLIK):0]   doluluk_o
);
    localparam int             PW   = $clog2(DERINLIK);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  DOLU = CW'(DERINLIK);
    localparam logic [31:0]    NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {SIFIR, GETIR, IPTAL} durum_t;

    durum_t         durum_q;
    logic [31:0]    fps_q;        // address of the request being (or next to be) issued
    logic [31:0]    hedef_q;      // new fetch PC held while a cancelled request drains
    logic           bekliyor_q;   // a request was issued and the cache is still busy
    logic [PW-1:0]  oku_q;
    logic [PW-1:0]  yaz_q;
    logic [CW-1:0]  doluluk_q;

    logic [31:0]    buyruk_mem [DERINLIK];
    logic [30:0]    ps_mem     [DERINLIK];

    logic           istek;
    logic           iptal_istek;
    logic           bos_degil;
    logic           push;
    logic           pop;
    logic [30:0]    bas_ps;
    logic [31:0]    yeni_hedef;
    logic [31:0]    iptal_hedef;

    // Request, push/pop and redirect-target decode
    always_comb begin
        bos_degil   = (doluluk_q != '0);
        bas_ps      = ps_mem[oku_q];
        iptal_istek = yrt_atlanan_ps_gecerli_i | ddb_bosalt_i;
        // A busy request is never withdrawn; new ones need a free slot.
        istek       = (durum_q == IPTAL) ||
                      ((durum_q == GETIR) && (bekliyor_q || (doluluk_q < DOLU)));
        push        = (durum_q == GETIR) && istek && !l1b_bekle_i && !iptal_istek;
        pop         = bos_degil && !ddb_durdur_i && !iptal_istek;
        // Flush alone replays from the oldest unconsumed instruction.
        if (yrt_atlanan_ps_gecerli_i) begin
            yeni_hedef = {yrt_atlanan_ps_i, 1'b0};
        end else if (bos_degil) begin
            yeni_hedef = {bas_ps, 1'b0};
        end else begin
            yeni_hedef = fps_q;
        end
        // While cancelling, only a redirect changes the pending target.
        iptal_hedef = yrt_atlanan_ps_gecerli_i ? {yrt_atlanan_ps_i, 1'b0} : hedef_q;
    end

    // Fetch FSM, fetch PC and FIFO pointers/occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q    <= SIFIR;
            fps_q      <= BASLANGIC_PS;
            hedef_q    <= BASLANGIC_PS;
            bekliyor_q <= 1'b0;
            oku_q      <= '0;
            yaz_q      <= '0;
            doluluk_q  <= '0;
        end else begin
            case (durum_q)
                SIFIR: begin
                    durum_q <= GETIR;
                end
                GETIR: begin
                    if (iptal_istek) begin
                        oku_q      <= '0;
                        yaz_q      <= '0;
                        doluluk_q  <= '0;
                        bekliyor_q <= 1'b0;
                        if (istek && l1b_bekle_i) begin
                            durum_q <= IPTAL;
                            hedef_q <= yeni_hedef;
                        end else begin
                            fps_q <= yeni_hedef;
                        end
                    end else begin
                        bekliyor_q <= istek && l1b_bekle_i;
                        if (push) begin
                            yaz_q <= yaz_q + 1'b1;
                            fps_q <= fps_q + 32'd4;
                        end
                        if (pop) begin
                            oku_q <= oku_q + 1'b1;
                        end
                        case ({push, pop})
                            2'b10:   doluluk_q <= doluluk_q + 1'b1;
                            2'b01:   doluluk_q <= doluluk_q - 1'b1;
                            default: doluluk_q <= doluluk_q;
                        endcase
                    end
                end
                IPTAL: begin
                    if (!l1b_bekle_i) begin
                        fps_q      <= iptal_hedef;
                        durum_q    <= GETIR;
                        bekliyor_q <= 1'b0;
                    end else begin
                        hedef_q <= iptal_hedef;
                    end
                end
                default: begin
                    durum_q <= SIFIR;
                end
            endcase
        end
    end

    // FIFO storage; contents are only observed through the valid head
    always_ff @(posedge clk_i) begin
        if (push) begin
            buyruk_mem[yaz_q] <= l1b_deger_i;
            ps_mem[yaz_q]     <= fps_q[31:1];
        end
    end

    assign l1b_chip_select_n_o = !istek;
    assign l1b_adres_o         = fps_q;
    assign cyo_gecerli_o       = bos_degil;
    assign cyo_buyruk_o        = bos_degil ? buyruk_mem[oku_q] : NOP;
    assign cyo_ps_o            = bos_degil ? bas_ps : 31'd0;
    assign cyo_ps_artmis_o     = bos_degil ? (bas_ps + 31'd2) : 31'd0;
    assign doluluk_o           = doluluk_q;

endmodule
